// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM block-copy engine: default geometry and FSM state encoding.
package ram_dma_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LD,
        ST_WR,
        ST_DONE
    } dma_state_e;

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM: write on cen&wen, registered read data one cycle after cen&!wen.
module ram #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (cen) begin
            if (wen) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_copy_dma.sv
// Single-channel block copy engine driving a synchronous RAM: read, load, write, 3 cycles per word.
module ram_copy_dma
    import ram_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = ram_dma_pkg::ADDR_W,
    parameter int unsigned DATA_W = ram_dma_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [CNT_W-1:0]  len_eff;

    assign len_eff = (length > DEPTH) ? DEPTH : length;

    // Outputs are computed for the state being entered so every RAM pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cen_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    len_d = len_eff;
                    cnt_d = '0;
                    if (len_eff == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RD;
                        busy_d  = 1'b1;
                        cen_d   = 1'b1;
                        addr_d  = src_addr;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_LD;
                busy_d  = 1'b1;
            end
            ST_LD: begin
                state_d = ST_WR;
                busy_d  = 1'b1;
                data_d  = ram_dout;
                cen_d   = 1'b1;
                wen_d   = 1'b1;
                addr_d  = dst_q + cnt_q[ADDR_W-1:0];
                din_d   = ram_dout;
            end
            ST_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == len_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RD;
                    busy_d  = 1'b1;
                    cen_d   = 1'b1;
                    addr_d  = src_q + cnt_d[ADDR_W-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_cen  = cen_q;
    assign ram_wen  = wen_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;

endmodule

// File: tb/tb_ram_copy_dma.sv
// Self-checking bench for ram_copy_dma driving a real ram; expected writes are scoreboarded.
module tb_ram_copy_dma;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
    logic          dma_cen, dma_wen;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_din;
    logic [DW-1:0] ram_dout;

    logic          tb_own = 1'b1;
    logic          b_cen = 1'b0, b_wen = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_din = '0;
    logic          m_cen, m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;

    assign m_cen  = tb_own ? b_cen  : dma_cen;
    assign m_wen  = tb_own ? b_wen  : dma_wen;
    assign m_addr = tb_own ? b_addr : dma_addr;
    assign m_din  = tb_own ? b_din  : dma_din;

    always #5 clk = ~clk;

    ram_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done),
        .ram_cen(dma_cen), .ram_wen(dma_wen), .ram_addr(dma_addr),
        .ram_din(dma_din), .ram_dout(ram_dout)
    );

    ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk(clk), .cen(m_cen), .wen(m_wen), .addr(m_addr),
        .din(m_din), .dout(ram_dout)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    logic [DW-1:0] model [32];

    typedef struct {
        string       name;
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [5:0]  len;
        bit          rnd_fill;
        int          inj;
        int          exp_done;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every DMA write cycle must match the next expected (addr, data).
    always @(negedge clk) begin
        if (!tb_own && dma_cen && dma_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(dma_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(dma_addr), 32'(mon_e.a));
                check("wr_data", dma_din, mon_e.d);
            end
        end
    end

    task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        b_cen = 1'b1; b_wen = 1'b1; b_addr = a; b_din = d;
        @(negedge clk);
        b_cen = 1'b0; b_wen = 1'b0;
    endtask

    task automatic ram_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        b_cen = 1'b1; b_wen = 1'b0; b_addr = a;
        @(negedge clk);
        b_cen = 1'b0;
        d = ram_dout;
    endtask

    task automatic preload(input bit rnd);
        logic [DW-1:0] v;
        tb_own = 1'b1;
        for (int i = 0; i < 32; i++) begin
            v = rnd ? $urandom : DW'(i);
            model[i] = v;
            ram_write(AW'(i), v);
        end
    endtask

    task automatic check_mem(input string name);
        logic [DW-1:0] d;
        tb_own = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ram_read(AW'(i), d);
            check($sformatf("%s_mem[%0d]", name, i), d, model[i]);
        end
    endtask

    task automatic push_expected(input logic [AW-1:0] s, input logic [AW-1:0] t, input int n);
        logic [AW-1:0] a, b;
        wr_t w;
        for (int i = 0; i < n; i++) begin
            a = s + AW'(i);
            b = t + AW'(i);
            model[b] = model[a];
            w.a = b;
            w.d = model[a];
            exp_q.push_back(w);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_cen"},  32'(dma_cen), 0);
        check({name, "_wen"},  32'(dma_wen), 0);
        check({name, "_addr"}, 32'(dma_addr), 0);
        check({name, "_din"},  dma_din, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int leff, done_cnt, first_done, busy_cnt, cen_cnt;
        leff = (v.len > 6'd32) ? 32 : int'(v.len);
        preload(v.rnd_fill);
        push_expected(v.src, v.dst, leff);
        done_cnt = 0; first_done = 0; busy_cnt = 0; cen_cnt = 0;
        @(negedge clk);
        tb_own = 1'b0;
        start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
        for (int n = 1; n <= v.exp_done + 3; n++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
            if (busy) busy_cnt++;
            if (dma_cen) cen_cnt++;
            if (n == 1 || n == v.inj + 1) start = 1'b0;
            if (n == v.inj) begin
                start = 1'b1; src_addr = 5'd1; dst_addr = 5'd2; length = 6'd3;
            end
        end
        check({v.name, "_done_cycle"}, 32'(first_done), 32'(v.exp_done));
        check({v.name, "_done_pulses"}, 32'(done_cnt), 1);
        check({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'(3 * leff));
        check({v.name, "_cen_cycles"}, 32'(cen_cnt), 32'(2 * leff));
        check({v.name, "_sb_empty"}, 32'(exp_q.size()), 0);
        exp_q.delete();
        check_mem(v.name);
    endtask

    initial begin
        vecs[0] = '{"basic8",   5'd0,  5'd16, 6'd8,  1'b0, 0, 25};
        vecs[1] = '{"wrap6",    5'd28, 5'd2,  6'd6,  1'b1, 0, 19};
        vecs[2] = '{"len0",     5'd5,  5'd9,  6'd0,  1'b1, 0, 1};
        vecs[3] = '{"len40",    5'd3,  5'd10, 6'd40, 1'b1, 0, 97};
        vecs[4] = '{"overlap",  5'd0,  5'd1,  6'd4,  1'b0, 0, 13};
        vecs[5] = '{"midstart", 5'd8,  5'd20, 6'd5,  1'b1, 4, 16};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during LD of word 3 of an 8-word copy: only words 0..2 may land.
        begin
            int done_cnt, cen_cnt;
            preload(1'b0);
            push_expected(5'd0, 5'd16, 3);
            @(negedge clk);
            tb_own = 1'b0;
            start = 1'b1; src_addr = 5'd0; dst_addr = 5'd16; length = 6'd8;
            done_cnt = 0;
            for (int n = 1; n <= 11; n++) begin
                @(negedge clk);
                if (n == 1) start = 1'b0;
                if (done) done_cnt++;
                if (n == 11) reset = 1'b1;
            end
            @(negedge clk);
            reset = 1'b0;
            check_idle_outputs("midreset");
            cen_cnt = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (done) done_cnt++;
                if (dma_cen) cen_cnt++;
            end
            check("midreset_done_pulses", 32'(done_cnt), 0);
            check("midreset_cen_after", 32'(cen_cnt), 0);
            check("midreset_sb_empty", 32'(exp_q.size()), 0);
            exp_q.delete();
            check_mem("midreset");
        end

        // Reset and start together: reset wins and nothing starts.
        begin
            int act_cnt;
            @(negedge clk);
            tb_own = 1'b0;
            reset = 1'b1; start = 1'b1; src_addr = 5'd0; dst_addr = 5'd5; length = 6'd3;
            @(negedge clk);
            reset = 1'b0; start = 1'b0;
            check_idle_outputs("rst_start");
            act_cnt = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (dma_cen || done || busy) act_cnt++;
            end
            check("rst_start_activity", 32'(act_cnt), 0);
            check_mem("rst_start");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
